// File: rtl/ctrl_resolve_queue.sv
// ctrl_resolve_queue: small show-ahead FIFO that buffers resolved CTIs from the
// control execution lane and offers them to the predictor/BTB update port.
// Execute cannot be stalled, so a push into a full queue is dropped and counted.
module ctrl_resolve_queue #(
  parameter int DEPTH     = 4,
  parameter int DEPTH_LOG = 2,
  parameter int PC_W      = 32,
  parameter int TYPE_W    = 2,
  parameter int CTI_W     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 exceptionFlag_i,
  input  logic                 exeCtrlValid_i,
  input  logic [PC_W-1:0]      exeCtrlPC_i,
  input  logic [PC_W-1:0]      exeCtrlNPC_i,
  input  logic [TYPE_W-1:0]    exeCtrlType_i,
  input  logic                 exeCtrlDir_i,
  input  logic [CTI_W-1:0]     exeCtiID_i,
  input  logic                 updReady_i,
  output logic                 updValid_o,
  output logic [PC_W-1:0]      updPC_o,
  output logic [PC_W-1:0]      updNPC_o,
  output logic [TYPE_W-1:0]    updType_o,
  output logic                 updDir_o,
  output logic [CTI_W-1:0]     updCtiID_o,
  output logic [DEPTH_LOG:0]   count_o,
  output logic                 full_o,
  output logic [7:0]           dropCnt_o
);

  localparam int ENT_W = 2*PC_W + TYPE_W + 1 + CTI_W;
  localparam logic [DEPTH_LOG:0] FULL_CNT = (DEPTH_LOG+1)'(DEPTH);

  logic [ENT_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG-1:0] headPtr;
  logic [DEPTH_LOG-1:0] tailPtr;
  logic [DEPTH_LOG:0]   count;
  logic [7:0]           dropCnt;
  logic                 push;
  logic                 pop;
  logic                 accept;
  logic                 drop;
  logic                 full;
  logic                 empty;
  logic [ENT_W-1:0]     inEntry;

  // Saturating increment for the drop counter; it sticks at 255.
  function automatic logic [7:0] satInc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push    = exeCtrlValid_i && !exceptionFlag_i;
  assign pop     = !empty && updReady_i;
  // A pop in the same edge frees the slot, so a full queue can still accept.
  assign accept  = push && (!full || pop);
  assign drop    = push && !accept;
  assign inEntry = {exeCtrlPC_i, exeCtrlNPC_i, exeCtrlType_i, exeCtrlDir_i, exeCtiID_i};

  // Entry storage: written only at the tail on an accepted push, cleared on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (accept) begin
      mem[tailPtr] <= inEntry;
    end
  end

  // Pointers, occupancy and drop counter; a flush empties the queue but keeps drops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
      dropCnt <= '0;
    end else if (exceptionFlag_i) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
    end else begin
      if (accept) tailPtr <= tailPtr + 1'b1;
      if (pop)    headPtr <= headPtr + 1'b1;
      if (accept && !pop)      count <= count + 1'b1;
      else if (pop && !accept) count <= count - 1'b1;
      if (drop) dropCnt <= satInc8(dropCnt);
    end
  end

  assign {updPC_o, updNPC_o, updType_o, updDir_o, updCtiID_o} = mem[headPtr];
  assign updValid_o = !empty;
  assign count_o    = count;
  assign full_o     = full;
  assign dropCnt_o  = dropCnt;

endmodule

// File: tb/tb_ctrl_resolve_queue.sv
// tb_ctrl_resolve_queue: directed vector table plus randomized soak against a
// queue-based reference model of the resolve FIFO.
module tb_ctrl_resolve_queue;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] npc;
    logic [1:0]  typ;
    logic        dir;
    logic [3:0]  id;
  } ent_t;

  typedef struct {
    bit          vld;
    bit          fl;
    bit          rdy;
    logic [31:0] pc;
    bit          eValid;
    int          eCount;
    logic [31:0] ePC;
    int          eDrop;
    bit          eFull;
  } vec_t;

  logic        clk = 0;
  logic        reset = 0;
  logic        exceptionFlag_i = 0;
  logic        exeCtrlValid_i = 0;
  logic [31:0] exeCtrlPC_i = 0;
  logic [31:0] exeCtrlNPC_i = 0;
  logic [1:0]  exeCtrlType_i = 0;
  logic        exeCtrlDir_i = 0;
  logic [3:0]  exeCtiID_i = 0;
  logic        updReady_i = 0;
  logic        updValid_o;
  logic [31:0] updPC_o;
  logic [31:0] updNPC_o;
  logic [1:0]  updType_o;
  logic        updDir_o;
  logic [3:0]  updCtiID_o;
  logic [2:0]  count_o;
  logic        full_o;
  logic [7:0]  dropCnt_o;

  ctrl_resolve_queue #(.DEPTH(4), .DEPTH_LOG(2), .PC_W(32), .TYPE_W(2), .CTI_W(4)) dut (
    .clk(clk), .reset(reset), .exceptionFlag_i(exceptionFlag_i),
    .exeCtrlValid_i(exeCtrlValid_i), .exeCtrlPC_i(exeCtrlPC_i), .exeCtrlNPC_i(exeCtrlNPC_i),
    .exeCtrlType_i(exeCtrlType_i), .exeCtrlDir_i(exeCtrlDir_i), .exeCtiID_i(exeCtiID_i),
    .updReady_i(updReady_i), .updValid_o(updValid_o), .updPC_o(updPC_o),
    .updNPC_o(updNPC_o), .updType_o(updType_o), .updDir_o(updDir_o),
    .updCtiID_o(updCtiID_o), .count_o(count_o), .full_o(full_o), .dropCnt_o(dropCnt_o)
  );

  always #5 clk = ~clk;

  int   nComp = 0;
  int   nFail = 0;
  ent_t mq[$];
  int   mDrop = 0;
  vec_t vt[18];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nComp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ent_t mk(input logic [31:0] pc);
    ent_t e;
    e.pc  = pc;
    e.npc = pc + 32'h1000;
    e.typ = pc[13:12];
    e.dir = pc[12];
    e.id  = pc[15:12] + 4'd4;
    return e;
  endfunction

  function automatic ent_t rnd();
    ent_t e;
    e.pc  = $urandom;
    e.npc = $urandom;
    e.typ = 2'($urandom_range(0, 3));
    e.dir = 1'($urandom_range(0, 1));
    e.id  = 4'($urandom_range(0, 15));
    return e;
  endfunction

  task automatic drive(input bit vld, input bit fl, input bit rdy, input ent_t e);
    exeCtrlValid_i  = vld;
    exceptionFlag_i = fl;
    updReady_i      = rdy;
    exeCtrlPC_i     = e.pc;
    exeCtrlNPC_i    = e.npc;
    exeCtrlType_i   = e.typ;
    exeCtrlDir_i    = e.dir;
    exeCtiID_i      = e.id;
  endtask

  // Reference behaviour for one clock edge, from the queue's rules.
  task automatic modelStep(input bit vld, input bit fl, input bit rdy, input ent_t e);
    bit popM;
    if (fl) begin
      mq.delete();
    end else begin
      popM = rdy && (mq.size() > 0);
      if (vld && (mq.size() < DEPTH || popM)) begin
        if (popM) void'(mq.pop_front());
        mq.push_back(e);
      end else begin
        if (popM) void'(mq.pop_front());
        if (vld && mDrop < 255) mDrop++;
      end
    end
  endtask

  task automatic checkHead(input string tag, input ent_t e);
    check({tag, ".pc"},   64'(updPC_o),    64'(e.pc));
    check({tag, ".npc"},  64'(updNPC_o),   64'(e.npc));
    check({tag, ".type"}, 64'(updType_o),  64'(e.typ));
    check({tag, ".dir"},  64'(updDir_o),   64'(e.dir));
    check({tag, ".id"},   64'(updCtiID_o), 64'(e.id));
  endtask

  task automatic compareModel(input string tag);
    check({tag, ".valid"}, 64'(updValid_o), 64'(mq.size() != 0));
    check({tag, ".count"}, 64'(count_o),    64'(mq.size()));
    check({tag, ".full"},  64'(full_o),     64'(mq.size() == DEPTH));
    check({tag, ".drop"},  64'(dropCnt_o),  64'(mDrop));
    if (mq.size() != 0) checkHead(tag, mq[0]);
  endtask

  task automatic cycleModel(input string tag, input bit vld, input bit fl, input bit rdy, input ent_t e);
    @(negedge clk);
    drive(vld, fl, rdy, e);
    modelStep(vld, fl, rdy, e);
    @(posedge clk);
    #1;
    compareModel(tag);
  endtask

  task automatic setv(input int i, input bit vld, input bit fl, input bit rdy, input logic [31:0] pc,
                      input bit ev, input int ec, input logic [31:0] ep, input int ed, input bit ef);
    vt[i].vld = vld; vt[i].fl = fl; vt[i].rdy = rdy; vt[i].pc = pc;
    vt[i].eValid = ev; vt[i].eCount = ec; vt[i].ePC = ep; vt[i].eDrop = ed; vt[i].eFull = ef;
  endtask

  initial begin
    bit prevValid;
    // Directed vectors: inputs applied before an edge, expected state after it.
    setv(0,  1, 0, 0, 32'h1000, 1, 1, 32'h1000, 0, 0);
    setv(1,  1, 0, 0, 32'h2000, 1, 2, 32'h1000, 0, 0);
    setv(2,  1, 0, 0, 32'h3000, 1, 3, 32'h1000, 0, 0);
    setv(3,  1, 0, 0, 32'h4000, 1, 4, 32'h1000, 0, 1);
    setv(4,  1, 0, 0, 32'h5000, 1, 4, 32'h1000, 1, 1);
    setv(5,  0, 0, 1, 32'h0,    1, 3, 32'h2000, 1, 0);
    setv(6,  1, 0, 0, 32'h6000, 1, 4, 32'h2000, 1, 1);
    setv(7,  1, 0, 1, 32'h7000, 1, 4, 32'h3000, 1, 1);
    setv(8,  0, 0, 1, 32'h0,    1, 3, 32'h4000, 1, 0);
    setv(9,  0, 0, 1, 32'h0,    1, 2, 32'h6000, 1, 0);
    setv(10, 0, 0, 1, 32'h0,    1, 1, 32'h7000, 1, 0);
    setv(11, 0, 0, 1, 32'h0,    0, 0, 32'h0,    1, 0);
    setv(12, 0, 0, 1, 32'h0,    0, 0, 32'h0,    1, 0);
    setv(13, 1, 0, 0, 32'h8000, 1, 1, 32'h8000, 1, 0);
    setv(14, 1, 0, 0, 32'h9000, 1, 2, 32'h8000, 1, 0);
    setv(15, 1, 1, 1, 32'hA000, 0, 0, 32'h0,    1, 0);
    setv(16, 1, 0, 0, 32'hB000, 1, 1, 32'hB000, 1, 0);
    setv(17, 0, 1, 0, 32'h0,    0, 0, 32'h0,    1, 0);

    // Power-on reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst.valid", 64'(updValid_o), 64'd0);
    check("rst.count", 64'(count_o),    64'd0);
    check("rst.full",  64'(full_o),     64'd0);
    check("rst.drop",  64'(dropCnt_o),  64'd0);
    check("rst.pc",    64'(updPC_o),    64'd0);
    @(negedge clk);
    reset = 1;

    prevValid = 0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive(vt[i].vld, vt[i].fl, vt[i].rdy, mk(vt[i].pc));
      modelStep(vt[i].vld, vt[i].fl, vt[i].rdy, mk(vt[i].pc));
      #1;
      check($sformatf("v%0d.preValid", i), 64'(updValid_o), 64'(prevValid));
      @(posedge clk);
      #1;
      check($sformatf("v%0d.valid", i), 64'(updValid_o), 64'(vt[i].eValid));
      check($sformatf("v%0d.count", i), 64'(count_o),    64'(vt[i].eCount));
      check($sformatf("v%0d.drop", i),  64'(dropCnt_o),  64'(vt[i].eDrop));
      check($sformatf("v%0d.full", i),  64'(full_o),     64'(vt[i].eFull));
      if (vt[i].eValid) checkHead($sformatf("v%0d", i), mk(vt[i].ePC));
      prevValid = vt[i].eValid;
    end

    // Drop counter saturation while full with ready low.
    for (int i = 0; i < 4; i++) cycleModel("fill", 1, 0, 0, rnd());
    for (int i = 0; i < 300; i++) cycleModel("sat", 1, 0, 0, rnd());
    check("sat.drop255", 64'(dropCnt_o), 64'd255);

    // Reset pulled low between edges with three entries queued.
    cycleModel("pop1", 0, 0, 1, rnd());
    check("mid.count3", 64'(count_o), 64'd3);
    @(negedge clk);
    drive(0, 0, 0, rnd());
    #2;
    reset = 0;
    #1;
    check("midrst.valid", 64'(updValid_o), 64'd0);
    check("midrst.count", 64'(count_o),    64'd0);
    check("midrst.drop",  64'(dropCnt_o),  64'd0);
    check("midrst.full",  64'(full_o),     64'd0);
    check("midrst.pc",    64'(updPC_o),    64'd0);
    mq.delete();
    mDrop = 0;
    @(negedge clk);
    reset = 1;

    // Random push/pop/flush soak against the reference queue.
    for (int i = 0; i < 3000; i++) begin
      cycleModel("soak", $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0,
                 $urandom_range(0, 2) == 0, rnd());
    end

    $display("== %0d vectors applied, %0d miscompares ==", nComp, nFail);
    $finish;
  end

endmodule
